// File: rtl/key_step_gen.sv
`default_nettype none
// ============================================================================
// key_step_gen : pushbutton + slide switch conditioner -> one-cycle step pulse
//                and stable direction. Auto-repeat built when AUTO_REPEAT_EN set.
// Revision     : 1.0  initial release
// ============================================================================
module key_step_gen #(
    parameter int DB_CYC  = 1_000_000,
    parameter int RPT_DLY = 25_000_000,
    parameter int RPT_PER = 5_000_000,
    parameter int CW      = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic dir_sw,
    output logic step,
    output logic dir,
    output logic pressed
);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);
    localparam logic [1:0]    ST_IDLE = 2'd0;
`ifdef AUTO_REPEAT_EN
    localparam logic [1:0]    ST_HOLD_DLY = 2'd1;
    localparam logic [1:0]    ST_HOLD_RPT = 2'd2;
    localparam logic [CW-1:0] DLY_LAST    = CW'(RPT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST    = CW'(RPT_PER - 1);

    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
`else
    localparam logic [1:0]    ST_HOLD = 2'd1;
`endif

    logic          key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic          sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [CW-1:0] key_cnt_q, key_cnt_d, sw_cnt_q, sw_cnt_d;
    logic          key_stb_q, key_stb_d, sw_stb_q, sw_stb_d;
    logic          dir_q, dir_d, step_q, step_d;
    logic [1:0]    state_q, state_d;
    logic          key_acc;

    always_comb begin
        key_s1_d = key_n;
        key_s2_d = key_s1_q;
        sw_s1_d  = dir_sw;
        sw_s2_d  = sw_s1_q;
    end

    // Counter runs only while the synced level disagrees with the stable one
    always_comb begin
        key_cnt_d = '0;
        key_stb_d = key_stb_q;
        key_acc   = 1'b0;
        if (key_s2_q != key_stb_q) begin
            if (key_cnt_q == DB_LAST) begin
                key_stb_d = key_s2_q;
                key_acc   = 1'b1;
            end else begin
                key_cnt_d = key_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        sw_cnt_d = '0;
        sw_stb_d = sw_stb_q;
        if (sw_s2_q != sw_stb_q) begin
            if (sw_cnt_q == DB_LAST) begin
                sw_stb_d = sw_s2_q;
            end else begin
                sw_cnt_d = sw_cnt_q + CW'(1);
            end
        end
    end

    // Direction follows the switch only while the key is (next) released
    always_comb begin
        dir_d = key_stb_d ? sw_stb_d : dir_q;
    end

    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_acc && !key_s2_q) begin
                    step_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    state_d   = ST_HOLD_DLY;
                    rpt_cnt_d = '0;
`else
                    state_d   = ST_HOLD;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            ST_HOLD_DLY, ST_HOLD_RPT: begin
                // A release beats a coinciding repeat; expiry waits out a pulse in flight
                if (key_acc) begin
                    state_d = ST_IDLE;
                end else if (rpt_cnt_q == ((state_q == ST_HOLD_DLY) ? DLY_LAST : PER_LAST)) begin
                    if (!step_q) begin
                        step_d    = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ST_HOLD_RPT;
                    end
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CW'(1);
                end
            end
`else
            ST_HOLD: begin
                if (key_acc) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            sw_s1_q   <= 1'b0;
            sw_s2_q   <= 1'b0;
            key_cnt_q <= '0;
            sw_cnt_q  <= '0;
            key_stb_q <= 1'b1;
            sw_stb_q  <= 1'b0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            key_cnt_q <= key_cnt_d;
            sw_cnt_q  <= sw_cnt_d;
            key_stb_q <= key_stb_d;
            sw_stb_q  <= sw_stb_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            state_q   <= state_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign step    = step_q;
    assign dir     = dir_q;
    assign pressed = ~key_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_key_step_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for key_step_gen: window-based reference model predicts step
// cycles, pressed and dir; a negedge monitor compares against the DUT.
module tb_key_step_gen;
    localparam int DB_CYC  = 4;
    localparam int RPT_DLY = 10;
    localparam int RPT_PER = 3;
    localparam int CW      = 8;
`ifdef AUTO_REPEAT_EN
    localparam int LONG_STEPS = 10;
`else
    localparam int LONG_STEPS = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic key_n = 1'b0;
    logic dir_sw = 1'b0;
    logic step, dir, pressed;

    key_step_gen #(
        .DB_CYC (DB_CYC),
        .RPT_DLY(RPT_DLY),
        .RPT_PER(RPT_PER),
        .CW     (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .dir_sw (dir_sw),
        .step   (step),
        .dir    (dir),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int dut_steps = 0;
    int exp_q[$];

    // Model state: sample histories and the debounced levels they imply
    bit kh[$];
    bit sh[$];
    bit m_kstb = 1'b1;
    bit m_sstb = 1'b0;
    bit m_dir = 1'b0;
    bit m_nk, m_ns, m_es;
    int m_hold_t = 0;
    int m_dt;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // The level at edge e is the sample taken at e-2; a change is accepted once
    // the DB_CYC most recent such samples all disagree with the stable level.
    function automatic bit all_differ(input bit q[$], input bit stb);
        int n = q.size();
        for (int k = 2; k <= DB_CYC + 1; k++) begin
            if (q[n - 1 - k] == stb) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_es = 1'b0;
        if (!reset) begin
            kh.delete();
            sh.delete();
            for (int i = 0; i < DB_CYC + 3; i++) begin
                kh.push_back(1'b1);
                sh.push_back(1'b0);
            end
            m_kstb = 1'b1;
            m_sstb = 1'b0;
            m_dir  = 1'b0;
        end else begin
            kh.push_back(key_n);
            sh.push_back(dir_sw);
            if (kh.size() > DB_CYC + 3) begin
                kh.delete(0);
                sh.delete(0);
            end
            m_nk = all_differ(kh, m_kstb) ? !m_kstb : m_kstb;
            m_ns = all_differ(sh, m_sstb) ? !m_sstb : m_sstb;
            if (m_kstb && !m_nk) begin
                m_es = 1'b1;
                m_hold_t = cyc;
            end
`ifdef AUTO_REPEAT_EN
            else if (!m_kstb && !m_nk) begin
                m_dt = cyc - m_hold_t;
                if (m_dt >= RPT_DLY && (m_dt - RPT_DLY) % RPT_PER == 0) m_es = 1'b1;
            end
`endif
            m_kstb = m_nk;
            m_sstb = m_ns;
            if (m_kstb) m_dir = m_sstb;
        end
        if (m_es) exp_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("pressed", int'(pressed), int'(!m_kstb));
            check("dir", int'(dir), int'(m_dir));
            if (step === 1'b1) begin
                dut_steps++;
                if (exp_q.size() == 0) check("step_unexpected", cyc, -1);
                else check("step_cycle", cyc, exp_q.pop_front());
            end
            while (exp_q.size() > 0 && exp_q[0] < cyc) check("step_missed", -1, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r_cyc;
        int got;
        int s0;

        // Reset held with key pressed, then step after reset release
        reset = 1'b0; key_n = 1'b0; dir_sw = 1'b0;
        tick(3);
        reset = 1'b1;
        r_cyc = cyc;
        got = -1;
        for (int i = 0; i < 20 && got < 0; i++) begin
            @(negedge clk);
            if (step === 1'b1) got = cyc;
        end
        check("reset_to_step", got - r_cyc, DB_CYC + 2);
        key_n = 1'b1;
        tick(15);

        // Clean press and release
        key_n = 1'b0; tick(20);
        key_n = 1'b1; tick(15);

        // Bounce shorter than DB_CYC is rejected
        s0 = dut_steps;
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(1);
        key_n = 1'b0; tick(3);
        key_n = 1'b1; tick(15);
        check("bounce_steps", dut_steps - s0, 0);

        // Exactly DB_CYC low samples is accepted
        s0 = dut_steps;
        key_n = 1'b0; tick(4);
        key_n = 1'b1; tick(15);
        check("min_press_steps", dut_steps - s0, 1);

        // Direction frozen during a hold
        dir_sw = 1'b1; tick(10);
        check("dir_set", int'(dir), 1);
        key_n = 1'b0; tick(12);
        dir_sw = 1'b0; tick(8);
        check("dir_frozen", int'(dir), 1);
        key_n = 1'b1; tick(15);
        check("dir_after_release", int'(dir), 0);

        // Long hold; release acceptance lands on a repeat slot
        s0 = dut_steps;
        key_n = 1'b0; tick(37);
        key_n = 1'b1; tick(15);
        check("long_hold_steps", dut_steps - s0, LONG_STEPS);

        // Reset mid-hold, key still held afterwards
        key_n = 1'b0; tick(8);
        reset = 1'b0; tick(2);
        reset = 1'b1; tick(12);
        key_n = 1'b1; tick(15);

        // Randomized key/switch activity with occasional resets
        for (int i = 0; i < 400; i++) begin
            key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) dir_sw = ~dir_sw;
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 2));
                reset = 1'b1;
            end
            tick($urandom_range(1, 8));
        end
        key_n = 1'b1;
        tick(25);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
